// File: rtl/des_if.sv
// PipeIn/PipeOut word bus between the FrontPanel endpoints (master) and the DES buffer (slave).
interface des_if;
    logic        pipe_in_write;
    logic [15:0] pipe_in_data;
    logic        pipe_out_read;
    logic [15:0] pipe_out_data;

    modport master (output pipe_in_write, pipe_in_data, pipe_out_read, input pipe_out_data);
    modport slave  (input pipe_in_write, pipe_in_data, pipe_out_read, output pipe_out_data);
endinterface

// File: rtl/des_top.sv
// DES sample user logic: pipe-loaded word buffer encrypted/decrypted in place by an iterative DES core.
// Optional DES_LED_EN drives status onto the active-low LEDs; otherwise LEDs stay off.
module des_top #(
    parameter int MEM_WORDS = 8,
    parameter int ADDR_W    = 3
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic [15:0] ep10_wire,
    input  logic [15:0] ep08_wire,
    input  logic [15:0] ep09_wire,
    input  logic [15:0] ep0a_wire,
    input  logic [15:0] ep0b_wire,
    input  logic [15:0] ep40_trig,
    input  logic [15:0] ep41_trig,
    output logic [15:0] ep60_trig,
    des_if.slave        pipe,
    output logic [7:0]  led
);
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                  19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    // Each S-box is 64 nibbles, row-major, entry 0 in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};
    // Rounds (0-based) whose key rotation is a single bit.
    localparam logic [15:0] ONE_SH = 16'h8103;

    function automatic logic [63:0] f_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 0; k < 64; k++) y[63-k] = x[64-IP_T[k]];
        return y;
    endfunction

    function automatic logic [63:0] f_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 0; k < 64; k++) y[63-k] = x[64-FP_T[k]];
        return y;
    endfunction

    function automatic logic [55:0] f_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int k = 0; k < 56; k++) y[55-k] = x[64-PC1_T[k]];
        return y;
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int k = 0; k < 48; k++) y[47-k] = x[56-PC2_T[k]];
        return y;
    endfunction

    function automatic logic [31:0] f_feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s, y;
        logic [5:0]  b;
        int          idx;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int i = 0; i < 8; i++) begin
            b   = x[47-6*i -: 6];
            idx = int'({b[5], b[0], b[4:1]});
            s[31-4*i -: 4] = SBOX[i][255-4*idx -: 4];
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, STORE, DONE} state_t;
    state_t state, state_nx;

    logic [15:0]       mem [MEM_WORDS];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, blk;
    logic [31:0]       l, r;
    logic [55:0]       cd, cd_next;
    logic [47:0]       subkey;
    logic [3:0]        rnd;
    logic              mode_q, busy, done, idle, soft_rst, wr_en;
    logic [63:0]       blk_in, blk_out;

    localparam logic [ADDR_W-1:0] LAST_BLK = ADDR_W'(MEM_WORDS - 4);
    localparam logic [ADDR_W-1:0] LAST_WRD = ADDR_W'(MEM_WORDS - 1);

    assign soft_rst = ep10_wire[0];

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)        state <= IDLE;
        else if (soft_rst) state <= IDLE;
        else               state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ep40_trig[0]) state_nx = LOAD;
            LOAD:    state_nx = ROUND;
            ROUND:   if (rnd == 4'd15) state_nx = STORE;
            STORE:   state_nx = (blk == LAST_BLK) ? DONE : LOAD;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        idle = (state == IDLE);
        busy = !idle;
        done = (state == DONE);
    end

    assign ep60_trig = {15'b0, done};

    // Decrypt walks the schedule backwards: C0D0 equals C16D16, so use it then rotate right.
    always_comb begin
        if (mode_q) begin
            subkey  = f_pc2(cd);
            cd_next = ONE_SH[~rnd] ? {cd[28], cd[55:29], cd[0], cd[27:1]}
                                   : {cd[29:28], cd[55:30], cd[1:0], cd[27:2]};
        end else begin
            cd_next = ONE_SH[rnd] ? {cd[54:28], cd[55], cd[26:0], cd[27]}
                                  : {cd[53:28], cd[55:54], cd[25:0], cd[27:26]};
            subkey  = f_pc2(cd_next);
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) blk_in[63-16*i -: 16] = mem[int'(blk) + i];
    end
    assign blk_out = f_fp({r, l});

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            l <= '0; r <= '0; cd <= '0; mode_q <= 1'b0; rnd <= '0; blk <= '0;
        end else begin
            case (state)
                IDLE: blk <= '0;
                LOAD: begin
                    {l, r} <= f_ip(blk_in);
                    cd     <= f_pc1({ep0b_wire, ep0a_wire, ep09_wire, ep08_wire});
                    mode_q <= ep10_wire[4];
                    rnd    <= '0;
                end
                ROUND: begin
                    l   <= r;
                    r   <= l ^ f_feistel(r, subkey);
                    cd  <= cd_next;
                    rnd <= rnd + 4'd1;
                end
                STORE:   blk <= blk + ADDR_W'(4);
                default: ;
            endcase
        end
    end

    // A pointer reset on the same edge as a strobe wins, so the write is dropped too.
    assign wr_en = idle && !soft_rst && !ep41_trig[0] && pipe.pipe_in_write;

    always_ff @(posedge clk1) begin
        if (wr_en) mem[wr_ptr] <= pipe.pipe_in_data;
        if (state == STORE && !soft_rst)
            for (int i = 0; i < 4; i++) mem[int'(blk) + i] <= blk_out[63-16*i -: 16];
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0; rd_ptr <= '0;
        end else if (soft_rst || (idle && ep41_trig[0])) begin
            wr_ptr <= '0; rd_ptr <= '0;
        end else if (idle) begin
            if (pipe.pipe_in_write) wr_ptr <= (wr_ptr == LAST_WRD) ? '0 : wr_ptr + 1'b1;
            if (pipe.pipe_out_read) rd_ptr <= (rd_ptr == LAST_WRD) ? '0 : rd_ptr + 1'b1;
        end else if (done) begin
            rd_ptr <= '0;
        end
    end

    assign pipe.pipe_out_data = mem[rd_ptr];

`ifdef DES_LED_EN
    logic [2:0] wr3;
    assign wr3 = 3'(wr_ptr);
    assign led = ~{busy, mode_q, 3'b000, wr3};
`else
    logic unused_busy;
    assign unused_busy = busy;
    assign led = 8'hFF;
`endif

    logic unused_bits;
    assign unused_bits = ^{ep10_wire[15:5], ep10_wire[3:1], ep40_trig[15:1], ep41_trig[15:1]};
endmodule

// File: tb/tb_des_top.sv
// Directed bench for des_top: FIPS vectors, round trip, busy/abort handling, pointer wrap.
module tb_des_top;
    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ep10 = '0, ep08 = '0, ep09 = '0, ep0a = '0, ep0b = '0, ep40 = '0, ep41 = '0;
    logic [15:0] ep60;
    logic [7:0]  led;
    int          n_chk = 0, n_fail = 0;
    int          lat, np;
    logic        seen;

    des_if bus();

    des_top dut (
        .clk1(clk1), .rst_n(rst_n), .ep10_wire(ep10), .ep08_wire(ep08), .ep09_wire(ep09),
        .ep0a_wire(ep0a), .ep0b_wire(ep0b), .ep40_trig(ep40), .ep41_trig(ep41),
        .ep60_trig(ep60), .pipe(bus), .led(led)
    );

    always #5 clk1 = ~clk1;

    localparam logic [15:0] PT [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    localparam logic [15:0] CT [4] = '{16'h85E8, 16'h1354, 16'h0F0A, 16'hB405};
    localparam logic [15:0] RW [8] = '{16'h3C5A, 16'h1F2E, 16'h9D4B, 16'h0077,
                                       16'hFFFF, 16'h8001, 16'h6B6B, 16'hC0DE};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    task automatic wr(input logic [15:0] d);
        bus.pipe_in_write = 1'b1;
        bus.pipe_in_data  = d;
        tick();
        bus.pipe_in_write = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] exp);
        chk(tag, 64'(bus.pipe_out_data), 64'(exp));
        bus.pipe_out_read = 1'b1;
        tick();
        bus.pipe_out_read = 1'b0;
    endtask

    task automatic ptr_rst;
        ep41 = 16'h0001;
        tick();
        ep41 = '0;
    endtask

    task automatic set_key(input logic [15:0] b, input logic [15:0] a,
                           input logic [15:0] k9, input logic [15:0] k8);
        ep0b = b; ep0a = a; ep09 = k9; ep08 = k8;
    endtask

    // inj: 0 plain run, 1 strobes while busy, 2 soft reset during round 5
    task automatic run(input int inj, output int lat_o, output int np_o);
        lat_o = 0;
        np_o  = 0;
        ep40  = 16'h0001;
        tick();
        ep40  = '0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (ep60[0]) begin
                np_o++;
                if (lat_o == 0) lat_o = i;
                chk("ep60_upper", 64'(ep60[15:1]), 64'd0);
            end
            if (inj == 1 && i == 10) begin
                bus.pipe_in_write = 1'b1; bus.pipe_in_data = 16'hDEAD;
                bus.pipe_out_read = 1'b1; ep40 = 16'hFFFF; ep41 = 16'h0001;
            end else if (inj == 1 && i == 11) begin
                bus.pipe_in_write = 1'b0; bus.pipe_out_read = 1'b0; ep40 = '0; ep41 = '0;
            end
            if (inj == 2 && i == 6) ep10[0] = 1'b1;
            if (inj == 2 && i == 7) ep10[0] = 1'b0;
        end
    endtask

    initial begin
        bus.pipe_in_write = 1'b0;
        bus.pipe_in_data  = '0;
        bus.pipe_out_read = 1'b0;
        #12;
        chk("rst_ep60", 64'(ep60), 64'd0);
        chk("rst_led", 64'(led), 64'hFF);
        rst_n = 1'b1;
        tick();

        // FIPS encrypt, two identical blocks
        set_key(16'h1334, 16'h5779, 16'h9BBC, 16'hDFF1);
        ep10 = 16'h0000;
        ptr_rst();
        for (int b = 0; b < 2; b++) for (int i = 0; i < 4; i++) wr(PT[i]);
        run(0, lat, np);
        chk("enc_latency", 64'(lat), 64'd36);
        chk("enc_pulses", 64'(np), 64'd1);
        for (int b = 0; b < 2; b++) for (int i = 0; i < 4; i++) rd("enc_word", CT[i]);

        // FIPS decrypt
        ep10 = 16'h0010;
        ptr_rst();
        for (int b = 0; b < 2; b++) for (int i = 0; i < 4; i++) wr(CT[i]);
        run(0, lat, np);
        chk("dec_pulses", 64'(np), 64'd1);
        for (int b = 0; b < 2; b++) for (int i = 0; i < 4; i++) rd("dec_word", PT[i]);

        // Round trip in place with a second key
        set_key(16'hABCD, 16'h1234, 16'h3456, 16'h4567);
        ep10 = 16'h0000;
        ptr_rst();
        for (int i = 0; i < 8; i++) wr(RW[i]);
        run(0, lat, np);
        chk("rt_enc_latency", 64'(lat), 64'd36);
        chk("rt_enc_pulses", 64'(np), 64'd1);
        ep10 = 16'h0010;
        run(0, lat, np);
        chk("rt_dec_latency", 64'(lat), 64'd36);
        chk("rt_dec_pulses", 64'(np), 64'd1);
        for (int i = 0; i < 8; i++) rd("rt_word", RW[i]);

        // Strobes and start while busy are ignored
        set_key(16'h1334, 16'h5779, 16'h9BBC, 16'hDFF1);
        ep10 = 16'h0000;
        ptr_rst();
        for (int b = 0; b < 2; b++) for (int i = 0; i < 4; i++) wr(PT[i]);
        run(1, lat, np);
        chk("busy_latency", 64'(lat), 64'd36);
        chk("busy_pulses", 64'(np), 64'd1);
        for (int b = 0; b < 2; b++) for (int i = 0; i < 4; i++) rd("busy_word", CT[i]);
        wr(16'h5A5A);
        rd("busy_wrptr", 16'h5A5A);

        // Soft reset mid-operation
        ptr_rst();
        wr(16'h1111); wr(16'h2222); wr(16'h3333);
        rd("pre_abort", 16'h1111);
        run(2, lat, np);
        chk("abort_pulses", 64'(np), 64'd0);
        wr(16'h7777);
        rd("abort_ptrs", 16'h7777);
        run(0, lat, np);
        chk("post_abort_latency", 64'(lat), 64'd36);

        // Asynchronous reset clears the done pulse without a clock edge
        ep40 = 16'h0001;
        tick();
        ep40 = '0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            seen = ep60[0];
        end
        chk("async_done_seen", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_ep60", 64'(ep60), 64'd0);
        chk("async_led", 64'(led), 64'hFF);
        tick();
        rst_n = 1'b1;
        tick();

        // Nine writes wrap onto mem[0]; reads wrap the same way
        ptr_rst();
        for (int i = 0; i < 9; i++) wr(16'hA000 + 16'(i));
        rd("wrap_rd0", 16'hA008);
        for (int i = 1; i < 8; i++) rd("wrap_rd", 16'hA000 + 16'(i));
        rd("wrap_rd8", 16'hA008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
